// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: defaults, FSM states,
// buffered-entry layout and address helper.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_buffer.sv
// Two-entry out+skid holding register between instruction memory and IF/ID.
// The out entry always carries NOP_INSN while it is empty.
module fetch_buffer
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         push,
  input  fetch_entry_t push_entry,
  output logic         out_valid,
  output fetch_entry_t out_entry,
  output logic         skid_valid
);

  fetch_entry_t skid_entry;
  logic         consume;

  assign consume = out_valid & ~hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_entry  <= '{insn: NOP_INSN, pc: RESET_PC};
      skid_valid <= 1'b0;
      skid_entry <= '{insn: NOP_INSN, pc: RESET_PC};
    end else if (flush) begin
      out_valid      <= 1'b0;
      out_entry.insn <= NOP_INSN;
      skid_valid     <= 1'b0;
    end else if (consume) begin
      if (skid_valid) begin
        out_entry  <= skid_entry;
        skid_valid <= push;
        if (push) skid_entry <= push_entry;
      end else if (push) begin
        out_entry <= push_entry;
      end else begin
        out_valid      <= 1'b0;
        out_entry.insn <= NOP_INSN;
      end
    end else if (push) begin
      // A response arriving while IF/ID is stalled parks behind the out entry.
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_entry <= push_entry;
      end else begin
        skid_valid <= 1'b1;
        skid_entry <= push_entry;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding memory
// handshake, handles redirects and feeds IF/ID through fetch_buffer.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, req_pc_q;
  logic         started_q;
  logic         out_valid, skid_valid;
  fetch_entry_t out_entry;
  logic         accept, push;

  // Request is suppressed on the first cycle after reset and whenever the buffer cannot take a response.
  assign imem_req_o  = (state_q == ISSUE) & started_q & ~branch_taken_i
                     & ~((out_valid & stall_i) | skid_valid);
  assign imem_addr_o = pc_q;
  assign accept      = imem_req_o & imem_ready_i;
  assign push        = (state_q == WAIT) & imem_rvalid_i & ~branch_taken_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE:   if (accept) state_d = WAIT;
      WAIT: begin
        if (imem_rvalid_i)       state_d = ISSUE;
        else if (branch_taken_i) state_d = DISCARD;
      end
      DISCARD: if (imem_rvalid_i) state_d = ISSUE;
      default: state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ISSUE;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (branch_taken_i) begin
        pc_q <= word_align(branch_target_i);
      end else if (accept) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
    end
  end

  fetch_buffer #(
    .RESET_PC(RESET_PC),
    .NOP_INSN(NOP_INSN)
  ) u_buffer (
    .clk        (clk),
    .rst        (reset),
    .flush      (branch_taken_i),
    .hold       (stall_i),
    .push       (push),
    .push_entry ('{insn: imem_rdata_i, pc: req_pc_q}),
    .out_valid  (out_valid),
    .out_entry  (out_entry),
    .skid_valid (skid_valid)
  );

  assign valid_o       = out_valid;
  assign instruction_o = out_entry.insn;
  assign pc_o          = out_entry.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural memory, in-order PC-stream scoreboard,
// directed scenarios followed by randomized stall/ready/latency/redirect traffic.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, ready, rvalid, stall, branch, valid;
  logic [31:0] addr, rdata, target, insn, pc;
  logic        req2, rvalid2, valid2;
  logic [31:0] addr2, rdata2, insn2, pc2;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .reset(reset),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ready_i(ready),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .stall_i(stall), .branch_taken_i(branch), .branch_target_i(target),
    .instruction_o(insn), .pc_o(pc), .valid_o(valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ready_i(1'b1),
    .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
    .stall_i(1'b0), .branch_taken_i(1'b0), .branch_target_i(32'h0),
    .instruction_o(insn2), .pc_o(pc2), .valid_o(valid2)
  );

  int unsigned vectors = 0, miscompares = 0, deliveries = 0;
  int unsigned acc_count = 0, lat = 1, ready_pct = 100, cnt = 0;
  bit          busy = 0, stale = 0, prev_branch = 0;
  logic [31:0] resp_addr, last_acc_addr;
  logic [31:0] exp_q[$];
  logic [31:0] wrap_pc[2], wrap_insn[2];
  int unsigned wrap_n = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    exp_q.push_back({start[31:2], 2'b00});
  endtask

  task automatic wait_accept(input int unsigned bound);
    int unsigned n0 = acc_count;
    for (int unsigned i = 0; i < bound; i++) begin
      cycle();
      if (acc_count != n0) break;
    end
    if (acc_count == n0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int unsigned bound);
    int unsigned i = 0;
    while (!valid && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (!valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] t);
    branch = 1'b1;
    target = t;
    restart_stream(t);
    cycle();
    branch = 1'b0;
  endtask

  // Memory: one outstanding request, programmable latency and ready probability.
  initial begin
    bit acc, dlv;
    logic [31:0] a;
    ready = 1'b1; rvalid = 1'b0; rdata = '0;
    forever begin
      @(posedge clk);
      acc = req & ready & ~reset;
      dlv = rvalid;
      a   = addr;
      if (!reset && busy && !stale) check("one_outstanding", {31'd0, req}, 32'd0);
      #1;
      if (dlv) begin rvalid = 1'b0; busy = 0; stale = 0; end
      if (acc) begin
        check("addr_align", {30'd0, a[1:0]}, 32'd0);
        busy = 1; cnt = lat; resp_addr = a; last_acc_addr = a; acc_count++;
      end
      if (busy && !rvalid) begin
        if (cnt <= 1) begin rvalid = 1'b1; rdata = mem_word(resp_addr); end
        else cnt--;
      end
      if (!rvalid) rdata = $urandom;
      ready = !busy && ($urandom_range(99) < ready_pct);
    end
  end

  // Fixed 1-cycle memory for the wrap-around instance.
  initial begin
    bit acc;
    logic [31:0] a;
    rvalid2 = 1'b0; rdata2 = '0;
    forever begin
      @(posedge clk);
      acc = req2 & ~reset;
      a   = addr2;
      #1;
      rvalid2 = acc;
      rdata2  = acc ? mem_word(a) : $urandom;
    end
  end

  always @(negedge clk) begin
    if (!reset && valid2 && wrap_n < 2) begin
      wrap_pc[wrap_n]   = pc2;
      wrap_insn[wrap_n] = insn2;
      wrap_n++;
    end
  end

  // Monitor: every instruction IF/ID latches must be the next one in program order.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) prev_branch = 0;
    else begin
      if (!valid) check("nop_when_idle", insn, NOP_INSN_DEF);
      if (prev_branch) check("flush_after_redirect", {31'd0, valid}, 32'd0);
      if (branch) check("req_gated_on_redirect", {31'd0, req}, 32'd0);
      if (!branch && valid && !stall) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard_empty: got pc %h, expected no delivery", pc);
        end else begin
          e = exp_q.pop_front();
          check("pc", pc, e);
          check("insn", insn, mem_word(e));
          exp_q.push_back(e + 32'd4);
          deliveries++;
        end
      end
      prev_branch = branch;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; target = '0;
    restart_stream(RESET_PC_DEF);
    #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_insn", insn, NOP_INSN_DEF);
    check("rst_pc", pc, RESET_PC_DEF);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_wrap_pc", pc2, 32'hFFFF_FFFC);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 check("req_before_first_edge", {31'd0, req}, 32'd0);

    // Streaming with a 1-cycle memory: valid alternates every cycle.
    wait_valid(20);
    check("first_pc", pc, 32'h0);
    for (int unsigned i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("alt_valid", {31'd0, valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    repeat (4) cycle();
    check("wrap_count", wrap_n, 32'd2);
    check("wrap_pc0", wrap_pc[0], 32'hFFFF_FFFC);
    check("wrap_insn0", wrap_insn[0], 32'h0000_00FC);
    check("wrap_pc1", wrap_pc[1], 32'h0000_0000);
    check("wrap_insn1", wrap_insn[1], 32'h0000_0100);

    // Stall right after an issue: no new request, response held, then released.
    begin
      logic [31:0] held;
      wait_accept(20);
      held = last_acc_addr;
      stall = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
        cycle();
        check("stall_no_req", {31'd0, req}, 32'd0);
        if (i > 0) begin
          check("stall_valid_held", {31'd0, valid}, 32'd1);
          check("stall_pc_held", pc, held);
        end
      end
      stall = 1'b0;
    end

    // Redirect while waiting with no response yet: response discarded.
    lat = 3;
    wait_accept(20);
    redirect(32'h0000_0203);
    wait_accept(20);
    check("discard_next_addr", last_acc_addr, 32'h0000_0200);
    wait_valid(20);
    check("discard_next_pc", pc, 32'h0000_0200);

    // Redirect in the same cycle as rvalid while stalled.
    lat = 1;
    repeat (3) cycle();
    wait_accept(20);
    stall = 1'b1;
    redirect(32'h0000_0400);
    check("redirect_rvalid_valid", {31'd0, valid}, 32'd0);
    stall = 1'b0;
    wait_accept(20);
    check("redirect_rvalid_addr", last_acc_addr, 32'h0000_0400);

    // Randomized traffic.
    ready_pct = 70;
    for (int unsigned i = 0; i < 3000; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(31) == 0) redirect($urandom & 32'h0003_FFFF);
      else cycle();
    end
    stall = 1'b0; ready_pct = 100;
    repeat (20) cycle();
    check("random_progress", {31'd0, deliveries > 200}, 32'd1);

    // Reset while a request is outstanding; the late response must be ignored.
    lat = 3;
    wait_accept(20);
    cycle();
    reset = 1'b1;
    stale = busy;
    restart_stream(RESET_PC_DEF);
    #1;
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_insn", insn, NOP_INSN_DEF);
    check("midreset_pc", pc, RESET_PC_DEF);
    check("midreset_req", {31'd0, req}, 32'd0);
    cycle();
    reset = 1'b0;
    wait_accept(20);
    check("midreset_first_addr", last_acc_addr, RESET_PC_DEF);
    wait_valid(20);
    check("midreset_first_pc", pc, RESET_PC_DEF);
    repeat (10) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
